// File: rtl/charli_pattern_gen.sv
// charli_pattern_gen
//   Pattern source for the 6-LED Charlieplexing driver. Two raw pushbuttons
//   are synchronised, debounced and edge-detected: MODE cycles through the
//   animation modes, PAUSE freezes the animation. A prescaler produces the
//   slow animation step. The LED frame is registered and held between steps.
// Ports
//   clk        in   system clock, posedge
//   rst        in   asynchronous active-high reset
//   btn_mode   in   raw pushbutton, advance mode
//   btn_pause  in   raw pushbutton, toggle pause
//   sw[5:0]    in   static / blink pattern source
//   data[5:0]  out  LED frame, bit i = LED i
//   mode[2:0]  out  0 STATIC, 1 CHASE, 2 BOUNCE, 3 COUNT, 4 BLINK
//   paused     out  animation frozen
//   step_tick  out  one-cycle pulse per accepted animation step
module charli_pattern_gen #(
    parameter logic [23:0] TICK_DIV = 24'd12_500_000,
    parameter logic [15:0] DEB_CNT  = 16'd50_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_pause,
    input  logic [5:0] sw,
    output logic [5:0] data,
    output logic [2:0] mode,
    output logic       paused,
    output logic       step_tick
);

    typedef enum logic [2:0] {
        M_STATIC = 3'd0,
        M_CHASE  = 3'd1,
        M_BOUNCE = 3'd2,
        M_COUNT  = 3'd3,
        M_BLINK  = 3'd4
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Index 0 = MODE button, index 1 = PAUSE button.
    logic [1:0]  sync1_q, sync2_q;
    logic [1:0]  deb_lvl_q, deb_lvl_d;
    logic [1:0]  deb_prev_q;
    logic [15:0] deb_cnt_q [2];
    logic [15:0] deb_cnt_d [2];
    logic [1:0]  press;

    logic [23:0] presc_q, presc_d;
    logic [5:0]  data_q, data_d;
    mode_t       mode_q, mode_d;
    dir_t        dir_q, dir_d;
    logic        paused_q, paused_d;
    logic        step_q, step_d;

    logic        mode_press, pause_press, raw_tick, step;

    // ---- stage: synchroniser + debounce counters ----
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_lvl_d[i] = deb_lvl_q[i];
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_lvl_q[i]) begin
                // Level must differ for DEB_CNT consecutive cycles to be accepted.
                if (deb_cnt_q[i] == DEB_CNT - 16'd1) begin
                    deb_lvl_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_lvl_q  <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync1_q    <= {btn_pause, btn_mode};
            sync2_q    <= sync1_q;
            deb_lvl_q  <= deb_lvl_d;
            deb_prev_q <= deb_lvl_q;
            for (int i = 0; i < 2; i++) deb_cnt_q[i] <= deb_cnt_d[i];
        end
    end

    // Rising edge of the debounced level only; release gives no pulse.
    assign press       = deb_lvl_q & ~deb_prev_q;
    assign mode_press  = press[0];
    assign pause_press = press[1];

    // ---- stage: prescaler, mode/pause control and frame update ----
    assign raw_tick = (presc_q == TICK_DIV - 24'd1);
    // A mode press swallows a coincident tick so the new mode starts cleanly.
    assign step     = raw_tick & ~paused_q & ~mode_press & (mode_q != M_STATIC);

    always_comb begin
        presc_d  = (mode_press || raw_tick) ? '0 : presc_q + 24'd1;
        data_d   = data_q;
        mode_d   = mode_q;
        dir_d    = dir_q;
        paused_d = paused_q;
        step_d   = step;

        if (pause_press) paused_d = ~paused_q;

        if (mode_press) begin
            // Mode press overrides a simultaneous pause toggle: paused ends at 0.
            paused_d = 1'b0;
            case (mode_q)
                M_STATIC: begin mode_d = M_CHASE;  data_d = 6'b000001; end
                M_CHASE:  begin mode_d = M_BOUNCE; data_d = 6'b000001; dir_d = DIR_UP; end
                M_BOUNCE: begin mode_d = M_COUNT;  data_d = 6'd0; end
                M_COUNT:  begin mode_d = M_BLINK;  data_d = sw; end
                default:  begin mode_d = M_STATIC; data_d = sw; end
            endcase
        end else if (mode_q == M_STATIC) begin
            data_d = sw;
        end else if (step) begin
            case (mode_q)
                M_CHASE: data_d = {data_q[4:0], data_q[5]};
                M_BOUNCE: begin
                    // Reverse on reaching an end so each end LED is lit one step.
                    if (dir_q == DIR_UP && data_q[5]) begin
                        dir_d  = DIR_DOWN;
                        data_d = data_q >> 1;
                    end else if (dir_q == DIR_DOWN && data_q[0]) begin
                        dir_d  = DIR_UP;
                        data_d = data_q << 1;
                    end else if (dir_q == DIR_UP) begin
                        data_d = data_q << 1;
                    end else begin
                        data_d = data_q >> 1;
                    end
                end
                M_COUNT: data_d = data_q + 6'd1;
                default: data_d = (data_q != 6'd0) ? 6'd0 : sw;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q  <= '0;
            data_q   <= '0;
            mode_q   <= M_STATIC;
            dir_q    <= DIR_UP;
            paused_q <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            data_q   <= data_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            paused_q <= paused_d;
            step_q   <= step_d;
        end
    end

    assign data      = data_q;
    assign mode      = mode_q;
    assign paused    = paused_q;
    assign step_tick = step_q;

endmodule

// File: tb/tb_charli_pattern_gen.sv
module tb_charli_pattern_gen;

    localparam logic [23:0] TICK_DIV = 24'd4;
    localparam logic [15:0] DEB_CNT  = 16'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode;
    logic       btn_pause;
    logic [5:0] sw;
    logic [5:0] data;
    logic [2:0] mode;
    logic       paused;
    logic       step_tick;

    int n_checks = 0;
    int n_errors = 0;

    logic [5:0] exp_q [$];

    always #5 clk = ~clk;

    charli_pattern_gen #(
        .TICK_DIV(TICK_DIV),
        .DEB_CNT (DEB_CNT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_pause(btn_pause),
        .sw       (sw),
        .data     (data),
        .mode     (mode),
        .paused   (paused),
        .step_tick(step_tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] rotl(input logic [5:0] v);
        return {v[4:0], v[5]};
    endfunction

    // Scoreboard: every step while expectations are pending must match the head.
    always @(negedge clk) begin
        if (!rst && step_tick && exp_q.size() > 0) begin
            check("step_data", 32'(data), 32'(exp_q.pop_front()));
        end
    end

    task automatic wait_mode(input logic [2:0] m, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mode == m) break;
        end
        check("mode_reach", 32'(mode), 32'(m));
    endtask

    task automatic wait_paused(input logic v, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (paused == v) break;
        end
        check("paused_reach", 32'(paused), 32'(v));
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] chase_exp  [6]  = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
        logic [5:0] bounce_exp [12] = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h10,
                                        6'h08, 6'h04, 6'h02, 6'h01, 6'h02, 6'h04};
        logic [5:0] frozen;
        logic [5:0] v;
        int         cnt;
        int         changes;
        bit         found;

        rst       = 1'b1;
        btn_mode  = 1'b0;
        btn_pause = 1'b0;
        sw        = 6'b101010;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data), 32'd0);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_paused", 32'(paused), 32'd0);
        check("rst_step", 32'(step_tick), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("static_data", 32'(data), 32'h2A);
        check("static_mode", 32'(mode), 32'd0);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (step_tick) cnt++;
        end
        check("static_no_step", 32'(cnt), 32'd0);
        sw = 6'h15;
        @(negedge clk);
        check("static_follow", 32'(data), 32'h15);

        // Bouncy MODE press -> CHASE
        for (int i = 0; i < 5; i++) begin
            btn_mode = (i % 2 == 0);
            @(negedge clk);
        end
        btn_mode = 1'b1;
        wait_mode(3'd1, 10);
        check("chase_init", 32'(data), 32'h01);
        foreach (chase_exp[i]) exp_q.push_back(chase_exp[i]);
        repeat (5) @(negedge clk);
        btn_mode = 1'b0;
        wait_drain(100);
        check("single_advance", 32'(mode), 32'd1);

        // Pause in CHASE
        btn_pause = 1'b1;
        wait_paused(1'b1, 12);
        btn_pause = 1'b0;
        frozen  = data;
        cnt     = 0;
        changes = 0;
        repeat (20) begin
            @(negedge clk);
            if (step_tick) cnt++;
            if (data != frozen) changes++;
        end
        check("pause_no_step", 32'(cnt), 32'd0);
        check("pause_hold", 32'(changes), 32'd0);
        check("pause_flag", 32'(paused), 32'd1);
        btn_pause = 1'b1;
        wait_paused(1'b0, 12);
        check("pause_frozen", 32'(data), 32'(frozen));
        v = frozen;
        for (int i = 0; i < 3; i++) begin
            v = rotl(v);
            exp_q.push_back(v);
        end
        btn_pause = 1'b0;
        wait_drain(60);

        // BOUNCE
        repeat (4) @(negedge clk);
        btn_mode = 1'b1;
        wait_mode(3'd2, 12);
        check("bounce_init", 32'(data), 32'h01);
        foreach (bounce_exp[i]) exp_q.push_back(bounce_exp[i]);
        btn_mode = 1'b0;
        wait_drain(100);

        // COUNT, full wrap
        repeat (10) @(negedge clk);
        btn_mode = 1'b1;
        wait_mode(3'd3, 12);
        check("count_init", 32'(data), 32'd0);
        for (int k = 1; k <= 64; k++) exp_q.push_back(6'(k));
        btn_mode = 1'b0;
        wait_drain(400);

        // Mode press coincident with the tick that would make data 6
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (step_tick && data == 6'd4) begin
                found = 1'b1;
                break;
            end
        end
        check("count_sync", 32'(found), 32'd1);
        repeat (2) @(negedge clk);
        btn_mode = 1'b1;
        sw       = 6'h2D;
        repeat (5) @(negedge clk);
        check("count_pre", 32'(data), 32'd5);
        check("count_pre_mode", 32'(mode), 32'd3);
        @(negedge clk);
        check("drop_mode", 32'(mode), 32'd4);
        check("drop_data", 32'(data), 32'h2D);
        check("drop_step", 32'(step_tick), 32'd0);
        exp_q.push_back(6'h00);
        exp_q.push_back(6'h2D);
        exp_q.push_back(6'h00);
        exp_q.push_back(6'h2D);
        btn_mode = 1'b0;
        wait_drain(60);

        // BLINK -> STATIC wrap
        sw = 6'h3F;
        repeat (10) @(negedge clk);
        btn_mode = 1'b1;
        wait_mode(3'd0, 12);
        btn_mode = 1'b0;
        @(negedge clk);
        check("wrap_static_data", 32'(data), 32'h3F);
        check("wrap_paused", 32'(paused), 32'd0);

        // Reset in the middle of a debounce discards the press
        repeat (10) @(negedge clk);
        btn_mode = 1'b1;
        repeat (3) @(negedge clk);
        rst      = 1'b1;
        btn_mode = 1'b0;
        @(negedge clk);
        check("rst_mid_data", 32'(data), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_mid_mode", 32'(mode), 32'd0);
        check("rst_mid_static", 32'(data), 32'h3F);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
